// File: rtl/bin_to_bcd_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_serial_if
//  Description : Start/busy/valid handshake and result bus for the serial
//                binary-to-BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_serial_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  i_start;
    logic [WIDTH-1:0]      i_bin_in;
    logic                  o_busy;
    logic                  o_valid;
    logic [4*DIGITS-1:0]   o_bcd_out;
    logic [DIGITS-1:0]     o_blank_mask;

    // Requester side (e.g. the countdown timer)
    modport master (
        output i_start,
        output i_bin_in,
        input  o_busy,
        input  o_valid,
        input  o_bcd_out,
        input  o_blank_mask
    );

    // Converter side
    modport slave (
        input  i_start,
        input  i_bin_in,
        output o_busy,
        output o_valid,
        output o_bcd_out,
        output o_blank_mask
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_serial.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_serial
//  Description : Iterative double-dabble binary-to-BCD converter, one input
//                bit per clock. Optional leading-zero blanking mask is
//                enabled by defining BIN_TO_BCD_BLANK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_serial #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    bin_to_bcd_serial_if.slave   bus
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int BCD_W  = 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_bin;
    logic [BCD_W-1:0]  r_bcd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_valid;
    logic [BCD_W-1:0]  r_bcd_out;
    logic [BCD_W-1:0]  w_adj;

    // Add-3 correction applied to every digit that is 5 or more before the shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? (r_bcd[4*g +: 4] + 4'd3)
                                                            : r_bcd[4*g +: 4];
    end

    // Control FSM, shift datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_bcd_out <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_bin   <= bus.i_bin_in;
                        r_bcd   <= '0;
                        r_cnt   <= CNT_W'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Bits leaving the top of the BCD register are always zero
                    // when 10^DIGITS exceeds the largest input value.
                    {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_bcd_out <= r_bcd;
                    r_valid   <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BIN_TO_BCD_BLANK_EN
    logic [DIGITS-1:0] w_blank;
    logic [DIGITS-1:0] r_blank;

    // Ones digit is never blanked; a higher digit blanks when it and all above are zero
    assign w_blank[0] = 1'b0;
    for (genvar g = 1; g < DIGITS; g++) begin : g_blank
        assign w_blank[g] = (r_bcd[BCD_W-1:4*g] == '0);
    end

    // Blank mask is captured together with the BCD result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank <= '0;
        end else if (r_state == S_DONE) begin
            r_blank <= w_blank;
        end
    end

    assign bus.o_blank_mask = r_blank;
`else
    assign bus.o_blank_mask = '0;
`endif

    assign bus.o_busy    = r_busy;
    assign bus.o_valid   = r_valid;
    assign bus.o_bcd_out = r_bcd_out;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_serial
//  Description : Self-checking bench for bin_to_bcd_serial against a decimal
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_serial;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic clk;
    logic rst_n;

    bin_to_bcd_serial_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_serial #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    logic [11:0] last_exp;
    logic [2:0]  last_blank;
    int          order [256];

    // Reference: decimal digits by plain division
    function automatic logic [11:0] bcd_of(input int v);
        logic [11:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: digit i blanks when the value is below 10^i (i >= 1)
    function automatic logic [2:0] blank_of(input int v);
        logic [2:0] b;
        int         p;
        b = '0;
        p = 1;
`ifdef BIN_TO_BCD_BLANK_EN
        for (int i = 1; i < DIGITS; i++) begin
            p = p * 10;
            if (v < p) b[i] = 1'b1;
        end
`endif
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Idle cycles: no spurious Valid, result held
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_valid", 32'(bus.o_valid), 32'd0);
            check("idle_hold", 32'(bus.o_bcd_out), 32'(last_exp));
        end
    endtask

    // Called at a negedge; Start is sampled at the following posedge
    task automatic start_conv(input logic [7:0] v);
        bus.i_start  = 1'b1;
        bus.i_bin_in = v;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("busy_after_start", 32'(bus.o_busy), 32'd1);
        check("valid_low_after_start", 32'(bus.o_valid), 32'd0);
    endtask

    // Waits for Valid (k = cycles after the accepting edge), optionally
    // injecting ignored Starts / BinIn changes while busy.
    task automatic wait_result(input logic [7:0] v, input bit noise,
                               input int pulse_k, input logic [7:0] pulse_v);
        int k;
        bit stable_ok;
        bit busy_ok;
        k         = 1;
        stable_ok = 1'b1;
        busy_ok   = 1'b1;
        while (k < 40) begin
            if (bus.o_valid) break;
            if (bus.o_bcd_out !== last_exp) stable_ok = 1'b0;
            if (bus.o_busy !== 1'b1)        busy_ok   = 1'b0;
            if (k == pulse_k) begin
                bus.i_start  = 1'b1;
                bus.i_bin_in = pulse_v;
            end else if (noise && k <= WIDTH + 1) begin
                bus.i_start  = ($urandom_range(0, 2) == 0);
                bus.i_bin_in = 8'($urandom);
            end
            @(negedge clk);
            bus.i_start = 1'b0;
            k++;
        end
        check("latency", 32'(k), 32'(WIDTH + 2));
        check("bcd_out", 32'(bus.o_bcd_out), 32'(bcd_of(int'(v))));
        check("blank_mask", 32'(bus.o_blank_mask), 32'(blank_of(int'(v))));
        check("stable_between", 32'(stable_ok), 32'd1);
        check("busy_held", 32'(busy_ok), 32'd1);
        last_exp   = bcd_of(int'(v));
        last_blank = blank_of(int'(v));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        last_exp     = '0;
        last_blank   = '0;
        rst_n        = 1'b0;
        bus.i_start  = 1'b0;
        bus.i_bin_in = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_bcd", 32'(bus.o_bcd_out), 32'd0);
        check("rst_blank", 32'(bus.o_blank_mask), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Single conversion of 30
        start_conv(8'd30);
        wait_result(8'd30, 1'b0, 0, 8'd0);
        idle(2);

        // Back-to-back: second Start in the Valid cycle
        start_conv(8'd255);
        wait_result(8'd255, 1'b0, 0, 8'd0);
        start_conv(8'd0);
        wait_result(8'd0, 1'b0, 0, 8'd0);
        idle(2);

        // Start during SHIFT is ignored
        start_conv(8'd99);
        wait_result(8'd99, 1'b0, 3, 8'd42);
        idle(WIDTH + 4);

        // Reset mid-conversion aborts it
        start_conv(8'd200);
        wait_result(8'd200, 1'b0, 0, 8'd0);
        idle(1);
        start_conv(8'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_bcd", 32'(bus.o_bcd_out), 32'd0);
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        check("abort_valid", 32'(bus.o_valid), 32'd0);
        check("abort_blank", 32'(bus.o_blank_mask), 32'd0);
        last_exp   = '0;
        last_blank = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(WIDTH + 6);
        start_conv(8'd7);
        wait_result(8'd7, 1'b0, 0, 8'd0);

        // Full sweep in shuffled order with random gaps and busy-time noise
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int t;
            j        = int'($urandom_range(0, i));
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            idle(int'($urandom_range(0, 2)));
            start_conv(8'(order[i]));
            wait_result(8'(order[i]), bit'($urandom_range(0, 1)), 0, 8'd0);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
